seg_scan_driver: RTL and testbench
==================================

Name: seg_scan_driver

Overview:
Multiplexed hex 7-segment display driver. Consumes the divided slow clock from the clock divider as a scan-rate strobe and cycles through NUM_DIGITS digits, one at a time. Each digit change inserts an anode blanking gap to prevent ghosting. A shadow register, loaded on request, prevents mid-scan tearing. Sits between the clock divider and the board's segment/anode pins.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (2..8)
BLANK_CYCLES, 2, clk_i cycles with all anodes off between digits (>=1)
SEG_ACTIVE_LOW, 1, 1 = seg_o/dp_o low-true; 0 = high-true
AN_ACTIVE_LOW, 1, 1 = an_o low-true; 0 = high-true

Ports:
clk_i  input  1  system clock
reset_i  input  1  asynchronous, active-high reset
tick_i  input  1  slow clock from divider; level, asynchronous to use, rising edge = advance
value_i  input  4*NUM_DIGITS  hex nibbles; nibble 0 (bits 3:0) = rightmost digit
dp_i  input  NUM_DIGITS  decimal point per digit
load_i  input  1  capture value_i/dp_i into shadow
blank_lz_i  input  1  enable leading-zero blanking
seg_o  output  7  segments, bit order gfedcba
dp_o  output  1  decimal point for active digit
an_o  output  NUM_DIGITS  digit enables, one-hot when showing
digit_idx_o  output  $clog2(NUM_DIGITS)  index of digit currently/next shown

Behaviour:
- Clock is one domain (clk_i); reset is asynchronous and active-high, all state cleared immediately on reset_i assertion.
- Reset values: idx=0, state=SHOW, blank counter=0, shadow value=0, shadow dp=0, sync flops=0; seg_o, dp_o, an_o all inactive (levels per polarity params); digit_idx_o=0.
- tick_i passes a 2-flop synchronizer (s1,s2) plus delay flop d; tick_rise = s2 & ~d. Exactly one tick_rise pulse per tick_i rising edge regardless of high-time. tick_i held high never re-advances.
- FSM states:
  - SHOW: on tick_rise, go to BLANK, load cnt=BLANK_CYCLES-1.
  - BLANK: if cnt==0, go to SHOW and idx <= (idx==NUM_DIGITS-1) ? 0 : idx+1; else cnt--.
  - tick_rise while in BLANK is dropped (no queuing).
- Outputs are registered, updated every clk_i from current state/idx/shadow; one-cycle latency.
- SHOW: an_o has only bit idx active; seg_o = decode(shadow nibble idx); dp_o = shadow dp[idx].
- BLANK: all an_o inactive; seg_o and dp_o inactive.
- Decode, active-high gfedcba: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71. Bitwise invert when SEG_ACTIVE_LOW=1.
- Leading-zero blanking (blank_lz_i=1): digit k>0 is dark (seg_o inactive, dp_o still follows dp shadow, an_o still active) if nibbles k..NUM_DIGITS-1 are all zero. Digit 0 is never blanked.
- load_i: shadow <= value_i, dp shadow <= dp_i on the same edge. The new value first appears on seg_o the following cycle. Load is accepted in any state. Without load_i, the shadow holds.
- Simultaneous load_i and idx advance: the output register uses the new idx with the new shadow one cycle later.
- digit_idx_o = idx (registered state, not delayed).
- Reset mid-BLANK or mid-SHOW: immediate return to reset values. The first post-reset tick_rise enters BLANK normally.

Test Plan:
1. Reset: hold reset_i=1, toggle clk_i, load_i=1 -> seg_o=7F, dp_o=1, an_o=F, digit_idx_o=0. Release with no load -> digit 0 shows '0': seg_o=40, an_o=E.
2. Decode: load value_i=16'h1234, dp_i=0 -> digit 0 seg_o=19 ('4' inverted), an_o=E. Give 3 ticks (rising edges of tick_i) -> shows '3','2','1' with an_o=D,B,7.
3. Wrap and blank: after digit 3, next tick -> an_o=F for exactly BLANK_CYCLES=2 clk_i cycles, then digit_idx_o=0, an_o=E.
4. Sync/edge: tick_i held high 50 cycles -> exactly one advance, observed 3 clk_i after tick_i rise. Second tick arriving inside BLANK -> ignored, idx advances once.
5. Leading zeros: value_i=16'h0050, blank_lz_i=1 -> digit 3 and digit 2 dark (seg_o=7F, an_o active), digit 1 '5' (12), digit 0 '0' (40). blank_lz_i=0 -> digits 3 and 2 show '0'.
6. Async reset: assert reset_i mid-BLANK between clock edges -> outputs inactive immediately, idx=0. Deassert -> SHOW digit 0 with shadow=0.

Source files
------------

// File: rtl/seg_scan_driver.sv
// seg_scan_driver
// Multiplexed hex 7-segment display driver. A slow scan strobe from the clock
// divider steps through NUM_DIGITS digits one at a time. Every digit change
// inserts a short all-anodes-off gap so the previous digit's segments never
// ghost onto the next anode. Displayed data comes from a shadow register
// that only changes on load_i, so a value update never tears mid-scan.
//
// Ports:
//   clk_i        system clock
//   reset_i      asynchronous, active-high reset
//   tick_i       scan strobe (level, asynchronous); each rising edge advances
//   value_i      hex nibbles, nibble 0 (bits 3:0) is the rightmost digit
//   dp_i         decimal point per digit
//   load_i       capture value_i / dp_i into the shadow register
//   blank_lz_i   enable leading-zero blanking
//   seg_o        segments, bit order gfedcba (polarity per SEG_ACTIVE_LOW)
//   dp_o         decimal point of the active digit (polarity per SEG_ACTIVE_LOW)
//   an_o         digit enables, one-hot while showing (polarity per AN_ACTIVE_LOW)
//   digit_idx_o  index of the digit currently shown, or next to be shown
//
// state | meaning
// ------+---------------------------------------------------------------
// SHOW  | anode idx driven with its decoded nibble; waits for a scan tick
// BLANK | all anodes off for BLANK_CYCLES clocks, then idx advances

module seg_scan_driver #(
    parameter int NUM_DIGITS     = 4,
    parameter int BLANK_CYCLES   = 2,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          tick_i,
    input  logic [4*NUM_DIGITS-1:0]       value_i,
    input  logic [NUM_DIGITS-1:0]         dp_i,
    input  logic                          load_i,
    input  logic                          blank_lz_i,
    output logic [6:0]                    seg_o,
    output logic                          dp_o,
    output logic [NUM_DIGITS-1:0]         an_o,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx_o
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int CNT_W = $clog2(BLANK_CYCLES + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Inactive output levels; XOR with these converts active-high to pin polarity.
    localparam logic [6:0]            SEG_OFF = {7{SEG_ACTIVE_LOW}};
    localparam logic                  DP_OFF  = SEG_ACTIVE_LOW;
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{AN_ACTIVE_LOW}};

    localparam logic [0:0] ST_SHOW  = 1'b0;
    localparam logic [0:0] ST_BLANK = 1'b1;

    // Active-high gfedcba glyphs for 0-9, A, b, C, d, E, F.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            4'hF:    seg = 7'h71;
            default: seg = 7'h00;
        endcase
        return seg;
    endfunction

    // ------------------------------------------------------------------
    // Tick synchronizer and rising-edge detect
    // ------------------------------------------------------------------
    logic tick_s1_q, tick_s1_d;
    logic tick_s2_q, tick_s2_d;
    logic tick_dly_q, tick_dly_d;
    logic tick_rise;

    always_comb begin
        tick_s1_d  = tick_i;
        tick_s2_d  = tick_s1_q;
        tick_dly_d = tick_s2_q;
    end

    // One pulse per rising edge no matter how long tick_i stays high.
    assign tick_rise = tick_s2_q & ~tick_dly_q;

    // ------------------------------------------------------------------
    // Scan FSM with blanking down-counter
    // ------------------------------------------------------------------
    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        case (state_q)
            ST_SHOW: begin
                if (tick_rise) begin
                    state_d = ST_BLANK;
                    cnt_d   = CNT_LOAD;
                end
            end
            ST_BLANK: begin
                // A tick landing here is dropped on purpose: queuing it would
                // shorten the next digit's on-time and make the scan uneven.
                if (cnt_q == '0) begin
                    state_d = ST_SHOW;
                    idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_ONE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: state_d = ST_SHOW;
        endcase
    end

    // ------------------------------------------------------------------
    // Shadow register
    // ------------------------------------------------------------------
    logic [4*NUM_DIGITS-1:0] shadow_val_q, shadow_val_d;
    logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;

    always_comb begin
        shadow_val_d = shadow_val_q;
        shadow_dp_d  = shadow_dp_q;
        if (load_i) begin
            shadow_val_d = value_i;
            shadow_dp_d  = dp_i;
        end
    end

    // ------------------------------------------------------------------
    // Digit selection, leading-zero detect and output register
    // ------------------------------------------------------------------
    logic [3:0]            cur_nib;
    logic                  cur_dp;
    logic                  cur_dark;
    logic                  upper_zero;
    logic [NUM_DIGITS-1:0] an_sel;
    logic [6:0]            seg_act;

    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;

    always_comb begin
        cur_nib    = 4'h0;
        cur_dp     = 1'b0;
        cur_dark   = 1'b0;
        upper_zero = 1'b1;
        an_sel     = '0;
        // Walk from the most significant digit down so upper_zero means
        // "this nibble and every nibble to its left are zero" at digit k.
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            upper_zero = upper_zero & (shadow_val_q[4*k +: 4] == 4'h0);
            if (idx_q == IDX_W'(k)) begin
                cur_nib   = shadow_val_q[4*k +: 4];
                cur_dp    = shadow_dp_q[k];
                cur_dark  = upper_zero & (k != 0);
                an_sel[k] = 1'b1;
            end
        end

        seg_act = (blank_lz_i && cur_dark) ? 7'h00 : hex_to_seg(cur_nib);

        seg_d = SEG_OFF;
        dp_d  = DP_OFF;
        an_d  = AN_OFF;
        if (state_q == ST_SHOW) begin
            seg_d = seg_act ^ SEG_OFF;
            dp_d  = cur_dp ^ DP_OFF;
            an_d  = an_sel ^ AN_OFF;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            tick_s1_q    <= 1'b0;
            tick_s2_q    <= 1'b0;
            tick_dly_q   <= 1'b0;
            state_q      <= ST_SHOW;
            cnt_q        <= '0;
            idx_q        <= '0;
            shadow_val_q <= '0;
            shadow_dp_q  <= '0;
            seg_q        <= SEG_OFF;
            dp_q         <= DP_OFF;
            an_q         <= AN_OFF;
        end else begin
            tick_s1_q    <= tick_s1_d;
            tick_s2_q    <= tick_s2_d;
            tick_dly_q   <= tick_dly_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shadow_val_q <= shadow_val_d;
            shadow_dp_q  <= shadow_dp_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
        end
    end

    assign seg_o       = seg_q;
    assign dp_o        = dp_q;
    assign an_o        = an_q;
    assign digit_idx_o = idx_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver (4 digits, 2 blank cycles, active-low pins).
// Expected outputs come from a digit-level model: which digit should be lit,
// what glyph the shadow value implies, and a fixed tick-to-output timeline.
module tb_seg_scan_driver;

    localparam int N        = 4;
    localparam int B        = 2;
    // Edges from a tick_i rise to the FSM leaving SHOW (two sync flops + edge).
    localparam int SYNC_LAT = 3;
    localparam int STEP_LEN = SYNC_LAT + B + 4;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        tick_i;
    logic [15:0] value_i;
    logic [3:0]  dp_i;
    logic        load_i;
    logic        blank_lz_i;
    logic [6:0]  seg_o;
    logic        dp_o;
    logic [3:0]  an_o;
    logic [1:0]  digit_idx_o;

    seg_scan_driver #(
        .NUM_DIGITS(N), .BLANK_CYCLES(B), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i), .tick_i(tick_i), .value_i(value_i),
        .dp_i(dp_i), .load_i(load_i), .blank_lz_i(blank_lz_i), .seg_o(seg_o),
        .dp_o(dp_o), .an_o(an_o), .digit_idx_o(digit_idx_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    logic [13:0] obs;
    logic [13:0] exp_v;
    assign obs = {seg_o, dp_o, an_o, digit_idx_o};

    // Reference model state
    logic [15:0] m_val;
    logic [3:0]  m_dp;
    int          m_idx;
    bit          m_lz;

    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Packed {seg, dp, an, idx} for digit k lit with value v.
    function automatic logic [13:0] show_vec(int k, logic [15:0] v, logic [3:0] d, bit lz);
        logic [15:0] upper;
        logic [6:0]  seg;
        logic [3:0]  an;
        upper = v >> (4 * k);
        seg   = (lz && k > 0 && upper == 16'h0) ? 7'h7F : ~seg_tab[upper[3:0]];
        an    = ~(4'b0001 << k);
        return {seg, ~d[k], an, 2'(k)};
    endfunction

    function automatic logic [13:0] blank_vec(int k);
        return {7'h7F, 1'b1, 4'hF, 2'(k)};
    endfunction

    // Sample s after a tick rise: old digit until the FSM reacts, then B dark
    // samples (index flips on the last one), then the next digit.
    function automatic logic [13:0] step_vec(int s, int k_old, int k_new,
                                             logic [15:0] v, logic [3:0] d, bit lz);
        if (s <= SYNC_LAT)     return show_vec(k_old, v, d, lz);
        if (s < SYNC_LAT + B)  return blank_vec(k_old);
        if (s == SYNC_LAT + B) return blank_vec(k_new);
        return show_vec(k_new, v, d, lz);
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic test_reset();
        reset_i = 1'b1; load_i = 1'b1; value_i = 16'hBEEF; dp_i = 4'hF;
        tick_i = 1'b0; blank_lz_i = 1'b0;
        cyc(3);
        exp_v = {7'h7F, 1'b1, 4'hF, 2'd0};
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL reset_hold: got %h want %h (seg,dp,an,idx)", obs, exp_v);
        end
        load_i = 1'b0; reset_i = 1'b0;
        m_val = '0; m_dp = '0; m_idx = 0; m_lz = 1'b0;
        cyc(1);
        exp_v = show_vec(0, m_val, m_dp, m_lz);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL reset_release: got %h want %h (seg,dp,an,idx)", obs, exp_v);
        end
    endtask

    task automatic test_decode();
        int k_new;
        load_i = 1'b1; value_i = 16'h1234; dp_i = 4'h0;
        cyc(1);
        exp_v = show_vec(m_idx, m_val, m_dp, m_lz);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL load_latency: got %h want %h (seg,dp,an,idx)", obs, exp_v);
        end
        load_i = 1'b0; value_i = 16'($urandom); dp_i = 4'($urandom);
        m_val = 16'h1234; m_dp = 4'h0;
        cyc(1);
        exp_v = show_vec(m_idx, m_val, m_dp, m_lz);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL decode_d0: got %h want %h (seg,dp,an,idx)", obs, exp_v);
        end
        for (int t = 0; t < 3; t++) begin
            k_new = (m_idx + 1) % N;
            tick_i = 1'b1;
            for (int s = 1; s <= STEP_LEN; s++) begin
                cyc(1);
                exp_v = step_vec(s, m_idx, k_new, m_val, m_dp, m_lz);
                n_checks++;
                if (obs !== exp_v) begin
                    n_fail++;
                    $display("FAIL decode_scan s=%0d: got %h want %h (seg,dp,an,idx)", s, obs, exp_v);
                end
                if (s == 2) tick_i = 1'b0;
            end
            m_idx = k_new;
        end
    endtask

    task automatic test_wrap_blank();
        int k_new;
        k_new = (m_idx + 1) % N;
        tick_i = 1'b1;
        for (int s = 1; s <= STEP_LEN; s++) begin
            cyc(1);
            exp_v = step_vec(s, m_idx, k_new, m_val, m_dp, m_lz);
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL wrap_blank s=%0d: got %h want %h (seg,dp,an,idx)", s, obs, exp_v);
            end
            if (s == 1) tick_i = 1'b0;
        end
        m_idx = k_new;
    endtask

    task automatic test_glyphs();
        logic [15:0] pats [4] = '{16'h3210, 16'h7654, 16'hBA98, 16'hFEDC};
        int k_new;
        for (int p = 0; p < 4; p++) begin
            load_i = 1'b1; value_i = pats[p]; dp_i = 4'($urandom);
            cyc(1);
            m_val = value_i; m_dp = dp_i;
            load_i = 1'b0; value_i = 16'($urandom); dp_i = 4'($urandom);
            for (int t = 0; t < N; t++) begin
                k_new = (m_idx + 1) % N;
                tick_i = 1'b1;
                for (int s = 1; s <= STEP_LEN; s++) begin
                    cyc(1);
                    exp_v = step_vec(s, m_idx, k_new, m_val, m_dp, m_lz);
                    n_checks++;
                    if (obs !== exp_v) begin
                        n_fail++;
                        $display("FAIL glyph_scan p=%0d s=%0d: got %h want %h (seg,dp,an,idx)", p, s, obs, exp_v);
                    end
                    if (s == 3) tick_i = 1'b0;
                end
                m_idx = k_new;
            end
        end
    endtask

    task automatic test_tick_hold();
        int k_new;
        k_new = (m_idx + 1) % N;
        tick_i = 1'b1;
        for (int s = 1; s <= 54; s++) begin
            cyc(1);
            exp_v = step_vec(s, m_idx, k_new, m_val, m_dp, m_lz);
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL tick_hold s=%0d: got %h want %h (seg,dp,an,idx)", s, obs, exp_v);
            end
            if (s == 50) tick_i = 1'b0;
        end
        m_idx = k_new;
    endtask

    task automatic test_tick_in_blank();
        int k_new;
        k_new = (m_idx + 1) % N;
        tick_i = 1'b1;
        for (int s = 1; s <= 25; s++) begin
            cyc(1);
            exp_v = step_vec(s, m_idx, k_new, m_val, m_dp, m_lz);
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL tick_in_blank s=%0d: got %h want %h (seg,dp,an,idx)", s, obs, exp_v);
            end
            // Second rising edge is timed to reach the FSM while it is blanking.
            tick_i = (s == 2);
        end
        m_idx = k_new;
    endtask

    task automatic test_leading_zero();
        int k_new;
        for (int pass = 0; pass < 2; pass++) begin
            blank_lz_i = (pass == 0); m_lz = (pass == 0);
            load_i = 1'b1; value_i = 16'h0050; dp_i = 4'h0;
            cyc(1);
            m_val = 16'h0050; m_dp = 4'h0;
            load_i = 1'b0; value_i = 16'($urandom);
            cyc(1);
            exp_v = show_vec(m_idx, m_val, m_dp, m_lz);
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL lz_static lz=%0d: got %h want %h (seg,dp,an,idx)", m_lz, obs, exp_v);
            end
            for (int t = 0; t < N; t++) begin
                k_new = (m_idx + 1) % N;
                tick_i = 1'b1;
                for (int s = 1; s <= STEP_LEN; s++) begin
                    cyc(1);
                    exp_v = step_vec(s, m_idx, k_new, m_val, m_dp, m_lz);
                    n_checks++;
                    if (obs !== exp_v) begin
                        n_fail++;
                        $display("FAIL lz_scan lz=%0d s=%0d: got %h want %h (seg,dp,an,idx)", m_lz, s, obs, exp_v);
                    end
                    if (s == 1) tick_i = 1'b0;
                end
                m_idx = k_new;
            end
        end
    endtask

    task automatic test_load_at_advance();
        int          k_new;
        logic [15:0] nv;
        logic [3:0]  nd;
        for (int it = 0; it < 3; it++) begin
            nv = 16'($urandom); nd = 4'($urandom);
            k_new = (m_idx + 1) % N;
            tick_i = 1'b1;
            for (int s = 1; s <= STEP_LEN; s++) begin
                cyc(1);
                if (s >= SYNC_LAT + B + 1)
                    exp_v = step_vec(s, m_idx, k_new, nv, nd, m_lz);
                else
                    exp_v = step_vec(s, m_idx, k_new, m_val, m_dp, m_lz);
                n_checks++;
                if (obs !== exp_v) begin
                    n_fail++;
                    $display("FAIL load_at_advance s=%0d: got %h want %h (seg,dp,an,idx)", s, obs, exp_v);
                end
                if (s == 1) tick_i = 1'b0;
                // Load captured on the same edge that advances the index.
                if (s == SYNC_LAT + B - 1) begin
                    load_i = 1'b1; value_i = nv; dp_i = nd;
                end
                if (s == SYNC_LAT + B) begin
                    load_i = 1'b0; value_i = 16'($urandom); dp_i = 4'($urandom);
                end
            end
            m_idx = k_new; m_val = nv; m_dp = nd;
        end
    endtask

    task automatic test_random();
        int          act, hold, s_ld, total, k_new;
        bit          do_ld;
        logic [15:0] nv;
        logic [3:0]  nd;
        for (int it = 0; it < 60; it++) begin
            act = $urandom_range(0, 3);
            nv  = 16'($urandom);
            nd  = 4'($urandom);
            if ($urandom_range(0, 2) == 0) nv[15:8] = 8'h00;
            if (act == 0) begin
                load_i = 1'b1; value_i = nv; dp_i = nd;
                cyc(1);
                exp_v = show_vec(m_idx, m_val, m_dp, m_lz);
                n_checks++;
                if (obs !== exp_v) begin
                    n_fail++;
                    $display("FAIL rnd_load_old it=%0d: got %h want %h (seg,dp,an,idx)", it, obs, exp_v);
                end
                load_i = 1'b0; value_i = 16'($urandom); dp_i = 4'($urandom);
                m_val = nv; m_dp = nd;
                cyc(1);
                exp_v = show_vec(m_idx, m_val, m_dp, m_lz);
                n_checks++;
                if (obs !== exp_v) begin
                    n_fail++;
                    $display("FAIL rnd_load_new it=%0d: got %h want %h (seg,dp,an,idx)", it, obs, exp_v);
                end
            end else if (act == 1) begin
                m_lz = ~m_lz; blank_lz_i = m_lz;
                cyc(1);
                exp_v = show_vec(m_idx, m_val, m_dp, m_lz);
                n_checks++;
                if (obs !== exp_v) begin
                    n_fail++;
                    $display("FAIL rnd_lz it=%0d: got %h want %h (seg,dp,an,idx)", it, obs, exp_v);
                end
            end else begin
                hold  = $urandom_range(1, 8);
                do_ld = ($urandom_range(0, 1) == 1);
                s_ld  = $urandom_range(1, 6);
                total = ((hold > SYNC_LAT + B + 1) ? hold : SYNC_LAT + B + 1) + 3;
                k_new = (m_idx + 1) % N;
                tick_i = 1'b1;
                for (int s = 1; s <= total; s++) begin
                    cyc(1);
                    if (do_ld && s >= s_ld + 2)
                        exp_v = step_vec(s, m_idx, k_new, nv, nd, m_lz);
                    else
                        exp_v = step_vec(s, m_idx, k_new, m_val, m_dp, m_lz);
                    n_checks++;
                    if (obs !== exp_v) begin
                        n_fail++;
                        $display("FAIL rnd_step it=%0d s=%0d: got %h want %h (seg,dp,an,idx)", it, s, obs, exp_v);
                    end
                    if (s == hold) tick_i = 1'b0;
                    if (do_ld && s == s_ld) begin
                        load_i = 1'b1; value_i = nv; dp_i = nd;
                    end
                    if (do_ld && s == s_ld + 1) begin
                        load_i = 1'b0; value_i = 16'($urandom); dp_i = 4'($urandom);
                    end
                end
                m_idx = k_new;
                if (do_ld) begin
                    m_val = nv; m_dp = nd;
                end
            end
        end
    endtask

    task automatic test_async_reset();
        int k_new;
        blank_lz_i = 1'b0; m_lz = 1'b0;
        load_i = 1'b1; value_i = 16'hA5C3; dp_i = 4'hF;
        cyc(1);
        m_val = 16'hA5C3; m_dp = 4'hF;
        load_i = 1'b0;
        for (int it = 0; it < 4 && m_idx != 2; it++) begin
            k_new = (m_idx + 1) % N;
            tick_i = 1'b1;
            for (int s = 1; s <= STEP_LEN; s++) begin
                cyc(1);
                exp_v = step_vec(s, m_idx, k_new, m_val, m_dp, m_lz);
                n_checks++;
                if (obs !== exp_v) begin
                    n_fail++;
                    $display("FAIL arst_prep s=%0d: got %h want %h (seg,dp,an,idx)", s, obs, exp_v);
                end
                if (s == 1) tick_i = 1'b0;
            end
            m_idx = k_new;
        end
        // Enter BLANK, then reset between clock edges.
        tick_i = 1'b1;
        for (int s = 1; s <= SYNC_LAT + 1; s++) begin
            cyc(1);
            exp_v = step_vec(s, m_idx, (m_idx + 1) % N, m_val, m_dp, m_lz);
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL arst_blank s=%0d: got %h want %h (seg,dp,an,idx)", s, obs, exp_v);
            end
            if (s == 1) tick_i = 1'b0;
        end
        #2 reset_i = 1'b1;
        #1;
        exp_v = {7'h7F, 1'b1, 4'hF, 2'd0};
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL arst_immediate: got %h want %h (seg,dp,an,idx)", obs, exp_v);
        end
        cyc(2);
        reset_i = 1'b0;
        m_idx = 0; m_val = '0; m_dp = '0;
        cyc(1);
        exp_v = show_vec(m_idx, m_val, m_dp, m_lz);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL arst_release: got %h want %h (seg,dp,an,idx)", obs, exp_v);
        end
        k_new = 1;
        tick_i = 1'b1;
        for (int s = 1; s <= STEP_LEN; s++) begin
            cyc(1);
            exp_v = step_vec(s, m_idx, k_new, m_val, m_dp, m_lz);
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL arst_first_tick s=%0d: got %h want %h (seg,dp,an,idx)", s, obs, exp_v);
            end
            if (s == 1) tick_i = 1'b0;
        end
        m_idx = k_new;
    endtask

    initial begin
        reset_i = 1'b1; tick_i = 1'b0; load_i = 1'b0; blank_lz_i = 1'b0;
        value_i = '0; dp_i = '0;
        test_reset();
        test_decode();
        test_wrap_blank();
        test_glyphs();
        test_tick_hold();
        test_tick_in_blank();
        test_leading_zero();
        test_load_at_advance();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
